// File: rtl/rename_pkg.sv
// Shared definitions for the register-rename controller.
// Holds the default register counts, the derived index widths, the
// controller state encoding and the renamed-uop record layout.
package rename_pkg;

  localparam int NUM_ARCH_REGS_DEF = 8;
  localparam int NUM_PHYS_REGS_DEF = 16;
  localparam int AW_DEF            = $clog2(NUM_ARCH_REGS_DEF);
  localparam int PW_DEF            = $clog2(NUM_PHYS_REGS_DEF);
  localparam int CW_DEF            = $clog2(NUM_PHYS_REGS_DEF + 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } rename_state_e;

  typedef struct packed {
    logic              has_dest;
    logic [PW_DEF-1:0] phys_dest;
    logic              src1_valid;
    logic              src1_mapped;
    logic [PW_DEF-1:0] src1_phys;
    logic [AW_DEF-1:0] src1_arch;
    logic              src2_valid;
    logic              src2_mapped;
    logic [PW_DEF-1:0] src2_phys;
    logic [AW_DEF-1:0] src2_arch;
  } renamed_uop_t;

endpackage

// File: rtl/rename_free_list.sv
// Physical register free list.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   alloc_en          - consume alloc_phys at this edge (caller guarantees free_count != 0)
//   alloc_phys        - lowest-index free register, from the pre-free bitmap
//   free_valid/phys   - return a register; freeing an already-free one sets free_err
//   free_count        - number of free registers
//   free_err          - sticky double-free flag, cleared only by reset
module free_list
  import rename_pkg::*;
#(
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
  localparam int PW = $clog2(NUM_PHYS_REGS),
  localparam int CW = $clog2(NUM_PHYS_REGS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_en,
  output logic [PW-1:0] alloc_phys,
  input  logic          free_valid,
  input  logic [PW-1:0] free_phys,
  output logic [CW-1:0] free_count,
  output logic          free_err
);

  logic [NUM_PHYS_REGS-1:0] bitmap_q, bitmap_d;
  logic [CW-1:0]            free_count_q, free_count_d;
  logic                     free_err_q, free_err_d;
  logic                     free_ok;

  // Scan downward so the last hit is the lowest free index.
  always_comb begin
    alloc_phys = '0;
    for (int i = NUM_PHYS_REGS - 1; i >= 0; i--) begin
      if (bitmap_q[i]) alloc_phys = PW'(i);
    end
  end

  // Double-free detection looks at the pre-allocation bitmap, so a free and
  // an allocation of the same register in one cycle counts as a double free.
  always_comb begin
    free_ok      = free_valid && !bitmap_q[free_phys];
    bitmap_d     = bitmap_q;
    if (alloc_en) bitmap_d[alloc_phys] = 1'b0;
    if (free_ok)  bitmap_d[free_phys]  = 1'b1;
    free_count_d = free_count_q - {{(CW-1){1'b0}}, alloc_en}
                                + {{(CW-1){1'b0}}, free_ok};
    free_err_d   = free_err_q | (free_valid && bitmap_q[free_phys]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q     <= '1;
      free_count_q <= CW'(NUM_PHYS_REGS);
      free_err_q   <= 1'b0;
    end else begin
      bitmap_q     <= bitmap_d;
      free_count_q <= free_count_d;
      free_err_q   <= free_err_d;
    end
  end

  assign free_count = free_count_q;
  assign free_err   = free_err_q;

endmodule

// File: rtl/rename_ctrl.sv
// Register-rename stage: takes one decoded instruction per cycle, looks up
// its sources in an external RAT, allocates a physical destination from the
// free list, updates the RAT and presents the renamed uop one cycle later.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_*                     - decoded instruction, valid/ready handshake
//   rat_read{1,2}_*          - combinational source lookups (acceptance cycle)
//   rat_write_*              - RAT mapping update, taken at the clock edge
//   out_*                    - renamed instruction, valid/ready handshake
//   free_valid/free_phys     - registers returned by commit
//   flush                    - discard the held output, accept nothing
//   free_count, stall, free_err - free-list status
//
// state    | meaning
// ST_EMPTY | no renamed uop held, out_valid=0
// ST_HOLD  | renamed uop held on out_*, out_valid=1
module rename_ctrl
  import rename_pkg::*;
#(
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEF,
  localparam int AW = $clog2(NUM_ARCH_REGS),
  localparam int PW = $clog2(NUM_PHYS_REGS),
  localparam int CW = $clog2(NUM_PHYS_REGS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_has_dest,
  input  logic [AW-1:0] in_arch_dest,
  input  logic          in_src1_valid,
  input  logic [AW-1:0] in_arch_src1,
  input  logic          in_src2_valid,
  input  logic [AW-1:0] in_arch_src2,
  output logic          rat_read1_valid,
  output logic [AW-1:0] rat_arch_src1,
  input  logic [PW-1:0] rat_phys_src1,
  input  logic          rat_read1_found,
  output logic          rat_read2_valid,
  output logic [AW-1:0] rat_arch_src2,
  input  logic [PW-1:0] rat_phys_src2,
  input  logic          rat_read2_found,
  output logic          rat_write_valid,
  output logic [AW-1:0] rat_write_arch,
  output logic [PW-1:0] rat_write_phys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_has_dest,
  output logic [PW-1:0] out_phys_dest,
  output logic          out_src1_valid,
  output logic          out_src2_valid,
  output logic          out_src1_mapped,
  output logic          out_src2_mapped,
  output logic [PW-1:0] out_src1_phys,
  output logic [PW-1:0] out_src2_phys,
  output logic [AW-1:0] out_src1_arch,
  output logic [AW-1:0] out_src2_arch,
  input  logic          free_valid,
  input  logic [PW-1:0] free_phys,
  input  logic          flush,
  output logic [CW-1:0] free_count,
  output logic          stall,
  output logic          free_err
);

  rename_state_e state_q, state_d;
  logic          accept, alloc_en;
  logic [PW-1:0] alloc_phys;

  logic          has_dest_q, has_dest_d;
  logic [PW-1:0] phys_dest_q, phys_dest_d;
  logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic          s1_mapped_q, s1_mapped_d, s2_mapped_q, s2_mapped_d;
  logic [PW-1:0] s1_phys_q, s1_phys_d, s2_phys_q, s2_phys_d;
  logic [AW-1:0] s1_arch_q, s1_arch_d, s2_arch_q, s2_arch_d;

  free_list #(.NUM_PHYS_REGS(NUM_PHYS_REGS)) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_en),
    .alloc_phys (alloc_phys),
    .free_valid (free_valid),
    .free_phys  (free_phys),
    .free_count (free_count),
    .free_err   (free_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                               state_d = ST_EMPTY;
    else if (accept)                         state_d = ST_HOLD;
    else if (state_q == ST_HOLD && out_ready) state_d = ST_EMPTY;
  end

  // rst gates the handshake so nothing is accepted or written during reset.
  always_comb begin
    out_valid       = (state_q == ST_HOLD);
    in_ready        = !rst && !flush && (state_q == ST_EMPTY || out_ready)
                      && (!in_has_dest || free_count != '0);
    accept          = in_valid && in_ready;
    alloc_en        = accept && in_has_dest;
    stall           = !rst && in_valid && in_has_dest && (free_count == '0);
    rat_read1_valid = accept && in_src1_valid;
    rat_read2_valid = accept && in_src2_valid;
    rat_arch_src1   = in_arch_src1;
    rat_arch_src2   = in_arch_src2;
    rat_write_valid = alloc_en;
    rat_write_arch  = in_arch_dest;
    rat_write_phys  = alloc_phys;
  end

  // Lookups are combinational against the pre-write RAT, so a source equal
  // to the destination naturally sees the previous mapping.
  always_comb begin
    has_dest_d  = has_dest_q;
    phys_dest_d = phys_dest_q;
    s1_valid_d  = s1_valid_q;
    s1_mapped_d = s1_mapped_q;
    s1_phys_d   = s1_phys_q;
    s1_arch_d   = s1_arch_q;
    s2_valid_d  = s2_valid_q;
    s2_mapped_d = s2_mapped_q;
    s2_phys_d   = s2_phys_q;
    s2_arch_d   = s2_arch_q;
    if (accept) begin
      has_dest_d  = in_has_dest;
      phys_dest_d = in_has_dest ? alloc_phys : '0;
      s1_valid_d  = in_src1_valid;
      s1_mapped_d = in_src1_valid && rat_read1_found;
      s1_phys_d   = s1_mapped_d ? rat_phys_src1 : '0;
      s1_arch_d   = in_arch_src1;
      s2_valid_d  = in_src2_valid;
      s2_mapped_d = in_src2_valid && rat_read2_found;
      s2_phys_d   = s2_mapped_d ? rat_phys_src2 : '0;
      s2_arch_d   = in_arch_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      has_dest_q  <= 1'b0;
      phys_dest_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_mapped_q <= 1'b0;
      s1_phys_q   <= '0;
      s1_arch_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mapped_q <= 1'b0;
      s2_phys_q   <= '0;
      s2_arch_q   <= '0;
    end else begin
      has_dest_q  <= has_dest_d;
      phys_dest_q <= phys_dest_d;
      s1_valid_q  <= s1_valid_d;
      s1_mapped_q <= s1_mapped_d;
      s1_phys_q   <= s1_phys_d;
      s1_arch_q   <= s1_arch_d;
      s2_valid_q  <= s2_valid_d;
      s2_mapped_q <= s2_mapped_d;
      s2_phys_q   <= s2_phys_d;
      s2_arch_q   <= s2_arch_d;
    end
  end

  assign out_has_dest    = has_dest_q;
  assign out_phys_dest   = phys_dest_q;
  assign out_src1_valid  = s1_valid_q;
  assign out_src1_mapped = s1_mapped_q;
  assign out_src1_phys   = s1_phys_q;
  assign out_src1_arch   = s1_arch_q;
  assign out_src2_valid  = s2_valid_q;
  assign out_src2_mapped = s2_mapped_q;
  assign out_src2_phys   = s2_phys_q;
  assign out_src2_arch   = s2_arch_q;

endmodule
